// File: rtl/clock_pkg.sv
// clock_pkg
//   Shared types, limits and BCD helpers for the digital clock.
//   - bcd_digit_t / bcd2_t : one BCD digit / a two-digit BCD value
//   - MAX_SEC, MAX_MIN, MAX_HOUR24 : largest legal value of each field
//   - bcd_to_bin / bin_to_bcd      : two-digit BCD <-> binary
//   - bcd_in_range                 : digit validity plus numeric range check
//   - hour12_to_24 / hour24_to_12  : hour conversion between display modes
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;

  localparam int MAX_SEC    = 59;
  localparam int MAX_MIN    = 59;
  localparam int MAX_HOUR24 = 23;

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] b);
    return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
    bcd_digit_t t;
    bcd_digit_t o;
    t = 4'(v / 8'd10);
    o = 4'(v % 8'd10);
    return {t, o};
  endfunction

  // Both digits must be decimal before the numeric value means anything.
  function automatic logic bcd_in_range(input logic [7:0] b,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    logic [7:0] v;
    v = bcd_to_bin(b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (v >= lo) && (v <= hi);
  endfunction

  // 12 AM -> 00, 12 PM -> 12, any other PM hour gains 12.
  function automatic logic [7:0] hour12_to_24(input logic [7:0] hh12,
                                              input logic       pm);
    logic [7:0] v;
    v = bcd_to_bin(hh12);
    if (v == 8'd12) v = 8'd0;
    if (pm)         v = v + 8'd12;
    return bin_to_bcd(v);
  endfunction

  // 00 -> 12, 01..12 unchanged, 13..23 -> minus 12.
  function automatic logic [7:0] hour24_to_12(input logic [7:0] hh24);
    logic [7:0] v;
    v = bcd_to_bin(hh24);
    if (v == 8'd0)       v = 8'd12;
    else if (v > 8'd12)  v = v - 8'd12;
    return bin_to_bcd(v);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
//   Two-digit BCD counter that wraps from MODULUS-1 back to 00.
//   clk, reset (async, active-low)
//   inc      : advance by one this cycle
//   load     : overwrite with load_val (takes precedence over inc)
//   load_val : BCD value to load
//   val      : current count
//   val_next : value the count takes on the next edge
//   carry    : inc while at MODULUS-1, i.e. this edge wraps to 00
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic [7:0] val_next,
  output logic       carry
);

  localparam bcd_digit_t TOP_TENS = 4'((MODULUS - 1) / 10);
  localparam bcd_digit_t TOP_ONES = 4'((MODULUS - 1) % 10);

  bcd2_t cnt;
  bcd2_t cnt_next;
  logic  at_top;

  assign at_top = (cnt.tens == TOP_TENS) && (cnt.ones == TOP_ONES);
  assign carry  = inc && at_top;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    if (load) begin
      cnt_next = load_val;
    end else if (inc) begin
      if (at_top) begin
        cnt_next = '0;
      end else if (cnt.ones == 4'd9) begin
        cnt_next.tens = cnt.tens + 4'd1;
        cnt_next.ones = '0;
      end else begin
        cnt_next.ones = cnt.ones + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_next;
  end

  assign val      = cnt;
  assign val_next = cnt_next;

endmodule

// File: rtl/digital_clock_alarm.sv
// digital_clock_alarm
//   Real-time clock with 12/24-hour display, time load and sticky alarm.
//   Time is kept internally as 24-hour BCD; the display is decoded from it.
//   clk, reset (async, active-low)
//   ena                    : time-base qualifier for the prescaler
//   mode24                 : 1 = 24-hour display/load, 0 = 12-hour
//   load, load_hh/mm/ss,
//   load_pm                : one-cycle time-set strobe and BCD values
//   alarm_en, alarm_hh/mm  : alarm arm and 24-hour BCD alarm time
//   alarm_ack              : alarm clear strobe
//   hh, mm, ss, pm         : displayed time
//   sec_pulse              : one cycle per second advance, with the new time
//   load_err               : one cycle after a rejected load
//   alarm                  : sticky alarm flag
module digital_clock_alarm
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter bit RESET_MODE24  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       mode24,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_ack,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_pulse,
  output logic       load_err,
  output logic       alarm
);

  localparam logic [15:0] PRESC_TOP = 16'(TICKS_PER_SEC - 1);

  logic [15:0] presc;
  logic        tick;
  logic        adv;
  logic        mode24_eff;
  logic        hour_ok;
  logic        load_ok;
  logic [7:0]  ld_hour;
  logic        alarm_hit;

  logic [7:0]  sec_v, min_v, hour_v;
  logic [7:0]  sec_n, min_n, hour_n;
  logic        sec_c, min_c;
  logic        day_wrap_unused;

  // While reset is held the mode register sits at its reset value; once
  // released the mode follows the input combinationally.
  assign mode24_eff = reset ? mode24 : RESET_MODE24;

  // Load validation and conversion to the internal 24-hour form.
  always_comb begin
    hour_ok = bcd_in_range(load_hh, 8'd0, 8'(MAX_HOUR24));
    ld_hour = load_hh;
    if (!mode24_eff) begin
      hour_ok = bcd_in_range(load_hh, 8'd1, 8'd12);
      ld_hour = hour12_to_24(load_hh, load_pm);
    end
  end

  assign load_ok = load && hour_ok
                && bcd_in_range(load_mm, 8'd0, 8'(MAX_MIN))
                && bcd_in_range(load_ss, 8'd0, 8'(MAX_SEC));

  // Any load (valid or not) swallows a coincident advance.
  assign tick = ena && (presc == PRESC_TOP);
  assign adv  = tick && !load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (load) begin
      if (load_ok) presc <= '0;
    end else if (ena) begin
      presc <= tick ? '0 : presc + 16'd1;
    end
  end

  bcd_mod_counter #(.MODULUS(MAX_SEC + 1)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .inc      (adv),
    .load     (load_ok),
    .load_val (load_ss),
    .val      (sec_v),
    .val_next (sec_n),
    .carry    (sec_c)
  );

  bcd_mod_counter #(.MODULUS(MAX_MIN + 1)) u_min (
    .clk      (clk),
    .reset    (reset),
    .inc      (sec_c),
    .load     (load_ok),
    .load_val (load_mm),
    .val      (min_v),
    .val_next (min_n),
    .carry    (min_c)
  );

  bcd_mod_counter #(.MODULUS(MAX_HOUR24 + 1)) u_hour (
    .clk      (clk),
    .reset    (reset),
    .inc      (min_c),
    .load     (load_ok),
    .load_val (ld_hour),
    .val      (hour_v),
    .val_next (hour_n),
    .carry    (day_wrap_unused)
  );

  // Match on the time this advance produces, so loads can never fire it.
  assign alarm_hit = adv && alarm_en && (sec_n == 8'h00)
                  && (min_n == alarm_mm) && (hour_n == alarm_hh);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_pulse <= 1'b0;
      load_err  <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      sec_pulse <= adv;
      load_err  <= load && !load_ok;
      if (alarm_hit)                   alarm <= 1'b1;
      else if (alarm_ack || !alarm_en) alarm <= 1'b0;
    end
  end

  assign ss = sec_v;
  assign mm = min_v;
  assign hh = mode24_eff ? hour_v : hour24_to_12(hour_v);
  assign pm = (hour_v >= 8'h12);

endmodule

// File: tb/tb_digital_clock_alarm.sv
// tb_digital_clock_alarm
//   Directed bench for digital_clock_alarm with TICKS_PER_SEC=4.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_digital_clock_alarm;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       mode24;
  logic       load;
  logic [7:0] load_hh, load_mm, load_ss;
  logic       load_pm;
  logic       alarm_en;
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_ack;
  logic [7:0] hh, mm, ss;
  logic       pm, sec_pulse, load_err, alarm;

  int total = 0;
  int bad   = 0;

  digital_clock_alarm #(.TICKS_PER_SEC(4), .RESET_MODE24(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .mode24    (mode24),
    .load      (load),
    .load_hh   (load_hh),
    .load_mm   (load_mm),
    .load_ss   (load_ss),
    .load_pm   (load_pm),
    .alarm_en  (alarm_en),
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .alarm_ack (alarm_ack),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .pm        (pm),
    .sec_pulse (sec_pulse),
    .load_err  (load_err),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m,
                         input logic [7:0] s, input logic p);
    load_hh = h;
    load_mm = m;
    load_ss = s;
    load_pm = p;
    load    = 1'b1;
    step(1);
    load    = 1'b0;
  endtask

  task automatic check_time(input string tag, input logic [7:0] eh,
                            input logic [7:0] em, input logic [7:0] es,
                            input logic ep);
    check({tag, "_hh"}, hh, eh);
    check({tag, "_mm"}, mm, em);
    check({tag, "_ss"}, ss, es);
    check({tag, "_pm"}, pm, ep);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ena = 1'b1; mode24 = 1'b0; load = 1'b0;
    load_hh = '0; load_mm = '0; load_ss = '0; load_pm = 1'b0;
    alarm_en = 1'b0; alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_ack = 1'b0;

    // Reset state, 12-hour view: 12:00:00 AM.
    step(2);
    check_time("rst", 8'h12, 8'h00, 8'h00, 1'b0);
    check("rst_pulse", sec_pulse, 1'b0);
    check("rst_err",   load_err,  1'b0);
    check("rst_alarm", alarm,     1'b0);

    // Release in 24-hour mode: first advance after exactly four ena cycles.
    reset = 1'b1; mode24 = 1'b1; #1;
    check("rel_hh24", hh, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      step(1);
      check("pre_ss", ss, 8'h00);
      check("pre_pulse", sec_pulse, 1'b0);
    end
    step(1);
    check("adv1_ss", ss, 8'h01);
    check("adv1_pulse", sec_pulse, 1'b1);
    step(1);
    check("adv1_pulse_off", sec_pulse, 1'b0);
    step(3);
    check("adv2_ss", ss, 8'h02);
    check("adv2_pulse", sec_pulse, 1'b1);

    // 11:59:59 PM rolls over to midnight.
    mode24 = 1'b0;
    do_load(8'h11, 8'h59, 8'h59, 1'b1);
    check_time("ld_pm", 8'h11, 8'h59, 8'h59, 1'b1);
    check("ld_pm_err", load_err, 1'b0);
    step(3);
    check("ld_pm_hold_ss", ss, 8'h59);
    step(1);
    check_time("midnight12", 8'h12, 8'h00, 8'h00, 1'b0);
    check("midnight_pulse", sec_pulse, 1'b1);
    mode24 = 1'b1; #1;
    check_time("midnight24", 8'h00, 8'h00, 8'h00, 1'b0);

    // 11:59:59 AM rolls over to noon; mode change shows at once.
    mode24 = 1'b0;
    do_load(8'h11, 8'h59, 8'h59, 1'b0);
    check_time("ld_am", 8'h11, 8'h59, 8'h59, 1'b0);
    step(4);
    check_time("noon12", 8'h12, 8'h00, 8'h00, 1'b1);
    mode24 = 1'b1; #1;
    check_time("noon24", 8'h12, 8'h00, 8'h00, 1'b1);

    // Rejected loads: hour 24 in 24-hour mode, then a non-decimal digit.
    do_load(8'h24, 8'h00, 8'h00, 1'b0);
    check("bad24_err", load_err, 1'b1);
    check_time("bad24", 8'h12, 8'h00, 8'h00, 1'b1);
    step(1);
    check("bad24_err_off", load_err, 1'b0);
    do_load(8'h1A, 8'h00, 8'h00, 1'b0);
    check("bad1a_err", load_err, 1'b1);
    check("bad1a_hh", hh, 8'h12);
    step(2);
    check("bad1a_err_off", load_err, 1'b0);
    check("bad1a_ss", ss, 8'h00);

    // Prescaler now sits on its wrap value: load wins over the advance.
    do_load(8'h05, 8'h06, 8'h07, 1'b0);
    check_time("coinc", 8'h05, 8'h06, 8'h07, 1'b0);
    check("coinc_pulse", sec_pulse, 1'b0);
    check("coinc_err", load_err, 1'b0);
    step(3);
    check("coinc_ss_hold", ss, 8'h07);
    step(1);
    check("coinc_next_ss", ss, 8'h08);
    check("coinc_next_pulse", sec_pulse, 1'b1);

    // Alarm at 07:30: a load onto the alarm time never sets it.
    alarm_en = 1'b1;
    do_load(8'h07, 8'h30, 8'h00, 1'b0);
    check("alm_load_noset", alarm, 1'b0);
    do_load(8'h07, 8'h29, 8'h59, 1'b0);
    step(4);
    check_time("alm_hit", 8'h07, 8'h30, 8'h00, 1'b0);
    check("alm_set", alarm, 1'b1);
    step(1);
    check("alm_sticky", alarm, 1'b1);

    // Ack coinciding with a fresh match: set wins.
    do_load(8'h07, 8'h29, 8'h59, 1'b0);
    step(3);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    check("alm_ack_vs_set", alarm, 1'b1);

    // Disarming clears the flag.
    alarm_en = 1'b0;
    step(1);
    check("alm_en_clear", alarm, 1'b0);

    // Re-arm, match, then a lone ack clears.
    alarm_en = 1'b1;
    do_load(8'h07, 8'h29, 8'h59, 1'b0);
    step(4);
    check("alm_set2", alarm, 1'b1);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    check("alm_ack_clear", alarm, 1'b0);

    // Set the alarm again, then reset mid-prescale between clock edges.
    do_load(8'h07, 8'h29, 8'h59, 1'b0);
    step(4);
    check("alm_set3", alarm, 1'b1);
    step(2);
    mode24 = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_time("async_rst", 8'h12, 8'h00, 8'h00, 1'b0);
    check("async_rst_alarm", alarm, 1'b0);
    check("async_rst_pulse", sec_pulse, 1'b0);
    check("async_rst_err", load_err, 1'b0);

    // After release a full four ena cycles are needed for the first advance.
    #2 reset = 1'b1;
    mode24 = 1'b1;
    step(3);
    check("rel2_ss", ss, 8'h00);
    check("rel2_pulse", sec_pulse, 1'b0);
    step(1);
    check("rel2_adv_ss", ss, 8'h01);
    check("rel2_adv_pulse", sec_pulse, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
